// File: rtl/can_pkg.sv
// Shared types and constants for the CAN transmit frame engine:
// FSM state encoding, CRC-15 polynomial, fixed field lengths and the frame descriptor.
package can_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SOF,
      ST_ARB,
      ST_CTRL,
      ST_DATA,
      ST_CRC,
      ST_CRC_DEL,
      ST_ACK_SLOT,
      ST_ACK_DEL,
      ST_EOF,
      ST_IFS
   } can_state_e;

   localparam logic [14:0] CRC_POLY    = 15'h4599;
   localparam int          EOF_BITS    = 7;
   localparam int          IFS_BITS    = 3;
   localparam int          STUFF_LIMIT = 5;

   typedef struct packed {
      logic        ide;
      logic        rtr;
      logic [28:0] id;
      logic [3:0]  dlc;
      logic [63:0] data;
   } can_frame_t;

   function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
      crc15_step = {crc[13:0], 1'b0} ^ (((b ^ crc[14]) == 1'b1) ? CRC_POLY : 15'h0000);
   endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 accumulator: one unstuffed bit per enabled cycle, clear has priority.
module can_crc15
   import can_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic        bit_i,
   output logic [14:0] crc_o
);

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         crc_o <= 15'h0000;
      end else if (en_i) begin
         crc_o <= crc15_step(crc_o, bit_i);
      end
   end

endmodule

// File: rtl/can_tx_frame.sv
// CAN 2.0A/2.0B transmit frame engine: bit timing, stuffing, CRC-15, ACK sampling.
// Optional CAN_TX_RETRY_EN: retransmit on missing ACK up to RETRY_MAX times.
module can_tx_frame
   import can_pkg::*;
#(
   parameter int CLK_DIV   = 16,
   parameter int SAMPLE_PT = 10,
   parameter int RETRY_MAX = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        frame_valid_i,
   output logic        frame_ready_o,
   input  logic        ide_i,
   input  logic        rtr_i,
   input  logic [28:0] id_i,
   input  logic [3:0]  dlc_i,
   input  logic [63:0] data_i,
   input  logic        rx_i,
   output logic        tx_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        ack_err_o
);

   localparam int                CNT_W      = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_SAMPLE = CNT_W'(SAMPLE_PT);
`ifdef CAN_TX_RETRY_EN
   localparam int                RETRY_LIMIT = RETRY_MAX;
`else
   localparam int                RETRY_LIMIT = 0 * RETRY_MAX;
`endif

   can_state_e       state_q, state_d;
   logic [5:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q;
   logic             tx_q;
   logic [2:0]       run_q;
   logic             ack_q;
   logic [7:0]       retry_q;
   can_frame_t       frm_q;
   logic [14:0]      crc;
   logic [6:0]       data_bits, cur_len;
   logic [31:0]      arb_vec;
   logic [5:0]       ctrl_vec;
   logic             bit_end, stuff_zone, do_stuff, field_last;
   logic             load, load_bit, feed_crc, restart, accept, retry, done;

   function automatic logic field_bit(input can_state_e st, input logic [5:0] idx,
                                      input logic [31:0] arb, input logic [5:0] ctrl,
                                      input logic [63:0] data, input logic [14:0] crc_v);
      case (st)
         ST_SOF:  field_bit = 1'b0;
         ST_ARB:  field_bit = arb[~idx[4:0]];
         ST_CTRL: field_bit = ctrl[3'd5 - idx[2:0]];
         ST_DATA: field_bit = data[~idx[5:0]];
         ST_CRC:  field_bit = crc_v[4'd14 - idx[3:0]];
         default: field_bit = 1'b1;
      endcase
   endfunction

   function automatic can_state_e next_field(input can_state_e st, input logic has_data);
      case (st)
         ST_SOF:      next_field = ST_ARB;
         ST_ARB:      next_field = ST_CTRL;
         ST_CTRL:     next_field = has_data ? ST_DATA : ST_CRC;
         ST_DATA:     next_field = ST_CRC;
         ST_CRC:      next_field = ST_CRC_DEL;
         ST_CRC_DEL:  next_field = ST_ACK_SLOT;
         ST_ACK_SLOT: next_field = ST_ACK_DEL;
         ST_ACK_DEL:  next_field = ST_EOF;
         ST_EOF:      next_field = ST_IFS;
         default:     next_field = ST_IDLE;
      endcase
   endfunction

   // Standard arbitration is left-aligned so both formats index from bit 31 downward.
   assign arb_vec   = frm_q.ide ? {frm_q.id[28:18], 2'b11, frm_q.id[17:0], frm_q.rtr}
                                : {frm_q.id[10:0], frm_q.rtr, 20'h00000};
   assign ctrl_vec  = {2'b00, frm_q.dlc};
   assign data_bits = frm_q.rtr    ? 7'd0 :
                      frm_q.dlc[3] ? 7'd64 : {1'b0, frm_q.dlc[2:0], 3'b000};

   always_comb begin
      case (state_q)
         ST_ARB:  cur_len = frm_q.ide ? 7'd32 : 7'd12;
         ST_CTRL: cur_len = 7'd6;
         ST_DATA: cur_len = data_bits;
         ST_CRC:  cur_len = 7'd15;
         ST_EOF:  cur_len = 7'(EOF_BITS);
         ST_IFS:  cur_len = 7'(IFS_BITS);
         default: cur_len = 7'd1;
      endcase
   end

   assign bit_end    = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
   assign stuff_zone = state_q inside {ST_SOF, ST_ARB, ST_CTRL, ST_DATA, ST_CRC};
   assign do_stuff   = stuff_zone && (run_q == 3'(STUFF_LIMIT));
   assign field_last = ({1'b0, idx_q} == (cur_len - 7'd1));

   // A stuff bit leaves idx_q on the last real bit, so the next bit_end resumes from it.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      load     = 1'b0;
      load_bit = 1'b1;
      feed_crc = 1'b0;
      restart  = 1'b0;
      accept   = 1'b0;
      retry    = 1'b0;
      done     = 1'b0;
      if (state_q == ST_IDLE) begin
         if (frame_valid_i) begin
            accept   = 1'b1;
            restart  = 1'b1;
            state_d  = ST_SOF;
            idx_d    = 6'd0;
            load     = 1'b1;
            load_bit = 1'b0;
         end
      end else if (bit_end) begin
         if (do_stuff) begin
            load     = 1'b1;
            load_bit = ~tx_q;
         end else if (!field_last) begin
            idx_d    = idx_q + 6'd1;
            load     = 1'b1;
            load_bit = field_bit(state_q, idx_d, arb_vec, ctrl_vec, frm_q.data, crc);
            feed_crc = state_q inside {ST_ARB, ST_CTRL, ST_DATA};
         end else if (state_q == ST_IFS) begin
            if (!ack_q && (int'(retry_q) < RETRY_LIMIT)) begin
               retry    = 1'b1;
               restart  = 1'b1;
               state_d  = ST_SOF;
               idx_d    = 6'd0;
               load     = 1'b1;
               load_bit = 1'b0;
            end else begin
               done    = 1'b1;
               state_d = ST_IDLE;
               idx_d   = 6'd0;
            end
         end else begin
            state_d  = next_field(state_q, data_bits != 7'd0);
            idx_d    = 6'd0;
            load     = 1'b1;
            load_bit = field_bit(state_d, 6'd0, arb_vec, ctrl_vec, frm_q.data, crc);
            feed_crc = state_d inside {ST_ARB, ST_CTRL, ST_DATA};
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         idx_q   <= 6'd0;
         cnt_q   <= '0;
         tx_q    <= 1'b1;
         run_q   <= 3'd0;
         ack_q   <= 1'b0;
         retry_q <= 8'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if ((state_q == ST_IDLE) || (state_d == ST_IDLE) || bit_end) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (load) begin
            tx_q  <= load_bit;
            run_q <= (restart || (load_bit != tx_q)) ? 3'd1 : run_q + 3'd1;
         end
         if (restart) begin
            ack_q <= 1'b0;
         end else if ((state_q == ST_ACK_SLOT) && (cnt_q == CNT_SAMPLE)) begin
            ack_q <= ~rx_i;
         end
         if (accept) begin
            retry_q <= 8'd0;
         end else if (retry) begin
            retry_q <= retry_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         frm_q.ide  <= ide_i;
         frm_q.rtr  <= rtr_i;
         frm_q.id   <= id_i;
         frm_q.dlc  <= dlc_i;
         frm_q.data <= data_i;
      end
   end

   can_crc15 u_crc (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (restart),
      .en_i  (feed_crc),
      .bit_i (load_bit),
      .crc_o (crc)
   );

   assign tx_o          = tx_q;
   assign frame_ready_o = (state_q == ST_IDLE);
   assign busy_o        = (state_q != ST_IDLE);
   assign done_o        = done;
   assign ack_err_o     = done & ~ack_q;

endmodule
